// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+RW, ACK, one data byte, ACK/NACK, STOP.
// Optional slave clock stretching (SCL_I input) is enabled with `define I2C_CLK_STRETCH_EN.
`timescale 1ns/1ps
module i2c_master_ctrl #(
    parameter int DIV = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rd_data,
    output logic       SCL_O,
    output logic       SDA_OE,
`ifdef I2C_CLK_STRETCH_EN
    input  logic       SCL_I,
`endif
    input  logic       SDA_I
);

    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic [7:0]    addr_rw_q, wdata_q, rx_q, rd_data_q;
    logic          rw_q, err_q, ack_err_q, done_q;
    logic          scl_q, scl_d, sda_oe_q, sda_oe_d;
    logic          accept, stretch, tick, sample, drive_low;

    assign accept = cmd_valid && (state_q == IDLE);

`ifdef I2C_CLK_STRETCH_EN
    // A slave holding SCL low in q1 freezes the divider on its last count.
    assign stretch = (state_q inside {ADDR, ADDR_ACK, DATA, DATA_ACK}) && (qtr_q == 2'd1)
                     && (div_q == DIV_LAST) && !SCL_I;
`else
    assign stretch = 1'b0;
`endif

    assign tick   = (state_q != IDLE) && (div_q == DIV_LAST) && !stretch;
    assign sample = tick && (qtr_q == 2'd2);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        div_d = div_q + DW'(1);
        if (state_q == IDLE || tick) begin
            div_d = '0;
        end else if (stretch) begin
            div_d = div_q;
        end
    end

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        if (accept) begin
            state_d = START;
            qtr_d   = 2'd0;
            bit_d   = 3'd0;
        end else if (tick) begin
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == 2'd3) begin
                bit_d = (state_q inside {ADDR, DATA}) ? bit_q + 3'd1 : 3'd0;
                case (state_q)
                    START:    state_d = ADDR;
                    ADDR:     if (bit_q == 3'd7) state_d = ADDR_ACK;
                    ADDR_ACK: state_d = err_q ? STOP : DATA;
                    DATA:     if (bit_q == 3'd7) state_d = DATA_ACK;
                    DATA_ACK: state_d = STOP;
                    default:  state_d = IDLE;
                endcase
            end
        end
    end

    // Bus levels are registered from the quarter being entered, so they switch on its first cycle.
    always_comb begin
        drive_low = 1'b0;
        if (state_d == ADDR) begin
            drive_low = !addr_rw_q[3'd7 - bit_d];
        end else if (state_d == DATA) begin
            drive_low = !rw_q && !wdata_q[3'd7 - bit_d];
        end
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            START: begin
                scl_d    = (qtr_d != 2'd3);
                sda_oe_d = (qtr_d != 2'd0);
            end
            ADDR, DATA: begin
                scl_d    = (qtr_d inside {2'd1, 2'd2});
                sda_oe_d = drive_low;
            end
            ADDR_ACK, DATA_ACK: begin
                scl_d    = (qtr_d inside {2'd1, 2'd2});
                sda_oe_d = 1'b0;
            end
            STOP: begin
                scl_d    = (qtr_d != 2'd0);
                sda_oe_d = (qtr_d inside {2'd0, 2'd1});
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            div_q     <= '0;
            addr_rw_q <= 8'h00;
            wdata_q   <= 8'h00;
            rx_q      <= 8'h00;
            rd_data_q <= 8'h00;
            rw_q      <= 1'b0;
            err_q     <= 1'b0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            state_q  <= state_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            scl_q    <= scl_d;
            sda_oe_q <= sda_oe_d;
            done_q   <= 1'b0;
            if (accept) begin
                addr_rw_q <= {cmd_addr, cmd_rw};
                rw_q      <= cmd_rw;
                wdata_q   <= cmd_wdata;
                err_q     <= 1'b0;
                ack_err_q <= 1'b0;
            end
            if (sample) begin
                case (state_q)
                    ADDR_ACK: if (SDA_I) err_q <= 1'b1;
                    DATA:     if (rw_q) rx_q <= {rx_q[6:0], SDA_I};
                    DATA_ACK: if (!rw_q && SDA_I) err_q <= 1'b1;
                    default:  ;
                endcase
            end
            if (tick && state_q == STOP && qtr_q == 2'd3) begin
                done_q    <= 1'b1;
                ack_err_q <= err_q;
                if (rw_q && !err_q) rd_data_q <= rx_q;
            end
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign ack_err   = ack_err_q;
    assign rd_data   = rd_data_q;
    assign SCL_O     = scl_q;
    assign SDA_OE    = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Self-checking bench for i2c_master_ctrl: directed table, back-to-back, stretch, random and reset.
// Builds with or without I2C_CLK_STRETCH_EN; stretch latency expectation follows the macro.
`timescale 1ns/1ps
module tb_i2c_master_ctrl;

    localparam int DIV      = 4;
    localparam int FULL_LAT = 80 * DIV;
    localparam int NACK_LAT = 44 * DIV;
`ifdef I2C_CLK_STRETCH_EN
    localparam int STRETCH_EXTRA = 10;
`else
    localparam int STRETCH_EXTRA = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic       cmd_rw;
    logic [7:0] cmd_wdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [7:0] rd_data;
    logic       SCL_O;
    logic       SDA_OE;
    logic       SDA_I;
    logic       slave_sda;
    logic       slave_hold;

    // Open-drain bus: either side pulling low wins.
    assign SDA_I = SDA_OE ? 1'b0 : slave_sda;
`ifdef I2C_CLK_STRETCH_EN
    logic SCL_I;
    assign SCL_I = SCL_O && !slave_hold;
`endif

    always #5 CLK = ~CLK;

    i2c_master_ctrl #(.DIV(DIV)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_rw    (cmd_rw),
        .cmd_wdata (cmd_wdata),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .rd_data   (rd_data),
        .SCL_O     (SCL_O),
        .SDA_OE    (SDA_OE),
`ifdef I2C_CLK_STRETCH_EN
        .SCL_I     (SCL_I),
`endif
        .SDA_I     (SDA_I)
    );

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        logic       aack;
        logic       dack;
        logic [7:0] rdbyte;
        int         lat;
        logic       err;
        logic [7:0] rd;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Master's SDA level at each SCL rise: 8 address/RW bits, ACK slot, [8 data bits, ACK slot], STOP rise.
    function automatic logic [31:0] exp_bits(input vec_t v);
        logic [31:0] e;
        e = {24'd0, v.addr, v.rw};
        e = {e[30:0], 1'b1};
        if (v.aack) e = {e[22:0], (v.rw ? 8'hFF : v.wdata), 1'b1};
        e = {e[30:0], 1'b0};
        return e;
    endfunction

    // What the slave puts on SDA from SCL rise n onward.
    function automatic logic slave_bit(input vec_t v, input int n);
        if (n == 9) return !v.aack;
        if (n >= 10 && n <= 17 && v.aack) return v.rw ? v.rdbyte[3'(17 - n)] : 1'b1;
        if (n == 18 && v.aack && !v.rw) return !v.dack;
        return 1'b1;
    endfunction

    task automatic run_txn(input string tag, input vec_t v, input bit hold_valid,
                           input vec_t nxt, input int stretch_bit);
        logic [31:0] seen;
        int          n_seen, starts, stops, k, lat, s0;
        logic        prev_scl, prev_oe;
        bit          win_ok;
        seen   = '0;
        n_seen = 0;
        starts = 0;
        stops  = 0;
        lat    = -1;
        win_ok = 1'b1;
        s0     = (6 + 4 * stretch_bit) * DIV - 1;
        @(negedge CLK);
        check({tag, "_ready_pre"}, 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_addr   = v.addr;
        cmd_rw     = v.rw;
        cmd_wdata  = v.wdata;
        slave_sda  = 1'b1;
        slave_hold = 1'b0;
        @(posedge CLK);
        #1;
        if (hold_valid) begin
            cmd_addr  = nxt.addr;
            cmd_rw    = nxt.rw;
            cmd_wdata = nxt.wdata;
        end else begin
            cmd_valid = 1'b0;
            cmd_addr  = 7'($urandom);
            cmd_rw    = 1'($urandom);
            cmd_wdata = 8'($urandom);
        end
        prev_scl = SCL_O;
        prev_oe  = SDA_OE;
        k = 0;
        while (lat < 0 && k < FULL_LAT + 64) begin
            @(posedge CLK);
            #1;
            k++;
            slave_hold = (stretch_bit >= 0) && (k >= s0) && (k < s0 + 10);
            if (!prev_scl && SCL_O) begin
                seen = {seen[30:0], !SDA_OE};
                n_seen++;
                slave_sda = slave_bit(v, n_seen);
            end
            if (prev_scl && SCL_O && (prev_oe != SDA_OE)) begin
                if (SDA_OE) starts++;
                else stops++;
            end
            prev_scl = SCL_O;
            prev_oe  = SDA_OE;
            if (done) lat = k;
            else if (!busy || cmd_ready) win_ok = 1'b0;
        end
        slave_hold = 1'b0;
        check({tag, "_latency"},  32'(lat),       32'(v.lat));
        check({tag, "_ack_err"},  32'(ack_err),   32'(v.err));
        check({tag, "_rd_data"},  32'(rd_data),   32'(v.rd));
        check({tag, "_ready_at_done"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy_at_done"},  32'(busy),      32'd0);
        check({tag, "_busy_window"},   32'(win_ok),    32'd1);
        check({tag, "_sda_bits"}, seen,           exp_bits(v));
        check({tag, "_scl_rises"}, 32'(n_seen),   v.aack ? 32'd19 : 32'd10);
        check({tag, "_starts"},   32'(starts),    32'd1);
        check({tag, "_stops"},    32'(stops),     32'd1);
        if (!hold_valid) begin
            @(posedge CLK);
            #1;
            check({tag, "_done_pulse"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        vec_t va, vb, vs, v;
        logic [7:0] rd_model;

        tbl[0] = '{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, FULL_LAT, 1'b0, 8'h00};
        tbl[1] = '{7'h50, 1'b0, 8'hA5, 1'b0, 1'b1, 8'h00, NACK_LAT, 1'b1, 8'h00};
        tbl[2] = '{7'h28, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3C, FULL_LAT, 1'b0, 8'h3C};
        tbl[3] = '{7'h7F, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, FULL_LAT, 1'b1, 8'h3C};
        tbl[4] = '{7'h01, 1'b1, 8'h00, 1'b1, 1'b0, 8'hFF, FULL_LAT, 1'b0, 8'hFF};
        tbl[5] = '{7'h00, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h00, FULL_LAT, 1'b0, 8'hFF};

        RST        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = 7'h00;
        cmd_rw     = 1'b0;
        cmd_wdata  = 8'h00;
        slave_sda  = 1'b1;
        slave_hold = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_scl",     32'(SCL_O),     32'd1);
        check("rst_sda_oe",  32'(SDA_OE),    32'd0);
        check("rst_ready",   32'(cmd_ready), 32'd1);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_done",    32'(done),      32'd0);
        check("rst_ack_err", 32'(ack_err),   32'd0);
        check("rst_rd_data", 32'(rd_data),   32'd0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i], 1'b0, tbl[i], -1);
        end

        // cmd_valid held through a transaction with new fields: only the first runs, second starts at done.
        va = '{7'h12, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00, FULL_LAT, 1'b0, 8'hFF};
        vb = '{7'h6B, 1'b1, 8'h00, 1'b1, 1'b0, 8'hC3, FULL_LAT, 1'b0, 8'hC3};
        run_txn("b2b_a", va, 1'b1, vb, -1);
        run_txn("b2b_b", vb, 1'b0, vb, -1);

        // Slave holds SCL low for 10 cycles in q1 of address bit 3.
        vs = '{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, FULL_LAT + STRETCH_EXTRA, 1'b0, 8'hC3};
        run_txn("stretch", vs, 1'b0, vs, 3);

        rd_model = 8'hC3;
        for (int i = 0; i < 24; i++) begin
            v.addr   = 7'($urandom);
            v.rw     = 1'($urandom);
            v.wdata  = 8'($urandom);
            v.aack   = v.rw ? 1'b1 : ($urandom_range(0, 3) != 0);
            v.dack   = ($urandom_range(0, 3) != 0);
            v.rdbyte = 8'($urandom);
            v.lat    = v.aack ? FULL_LAT : NACK_LAT;
            v.err    = !v.aack || (!v.rw && !v.dack);
            if (v.rw && v.aack) rd_model = v.rdbyte;
            v.rd     = rd_model;
            run_txn($sformatf("rnd%0d", i), v, 1'b0, v, -1);
            repeat ($urandom_range(0, 3)) @(posedge CLK);
        end

        // Leave non-zero status behind, then reset in the middle of DATA bit 4.
        v = '{7'h33, 1'b1, 8'h00, 1'b1, 1'b0, 8'h96, FULL_LAT, 1'b0, 8'h96};
        run_txn("pre_rst_rd", v, 1'b0, v, -1);
        v = '{7'h33, 1'b0, 8'h11, 1'b1, 1'b0, 8'h00, FULL_LAT, 1'b1, 8'h96};
        run_txn("pre_rst_wr", v, 1'b0, v, -1);

        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_addr  = 7'h50;
        cmd_rw    = 1'b0;
        cmd_wdata = 8'hA5;
        slave_sda = 1'b0;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        repeat (56 * DIV) @(posedge CLK);
        #1;
        check("mid_data4_scl",    32'(SCL_O),  32'd0);
        check("mid_data4_sda_oe", 32'(SDA_OE), 32'd1);
        check("mid_data4_busy",   32'(busy),   32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_scl",    32'(SCL_O),     32'd1);
        check("async_rst_sda_oe", 32'(SDA_OE),    32'd0);
        check("async_rst_ready",  32'(cmd_ready), 32'd1);
        @(negedge CLK);
        RST       = 1'b0;
        slave_sda = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst_ready",   32'(cmd_ready), 32'd1);
        check("post_rst_busy",    32'(busy),      32'd0);
        check("post_rst_ack_err", 32'(ack_err),   32'd0);
        check("post_rst_rd_data", 32'(rd_data),   32'd0);
        check("post_rst_done",    32'(done),      32'd0);

        run_txn("after_rst", tbl[0], 1'b0, tbl[0], -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
